// File: rtl/tone_detect.sv
// rtl/tone_detect.sv - classifies a square-wave input by half-period into one of four tones
// Drives a locked flag, tone index, one-hot LED and two seven-segment digit codes.
module tone_detect #(
  parameter int HP0      = 5000,
  parameter int HP1      = 6400,
  parameter int HP2      = 8000,
  parameter int HP3      = 9200,
  parameter int TOL      = 150,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 12000,
  parameter int CW       = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  output logic       tone_valid,
  output logic [1:0] tone_id,
  output logic [9:0] stled,
  output logic [4:0] data_1,
  output logic [4:0] data_0
);

  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
  localparam logic [CW:0] LO0 = (CW+1)'(HP0 - TOL), HI0 = (CW+1)'(HP0 + TOL);
  localparam logic [CW:0] LO1 = (CW+1)'(HP1 - TOL), HI1 = (CW+1)'(HP1 + TOL);
  localparam logic [CW:0] LO2 = (CW+1)'(HP2 - TOL), HI2 = (CW+1)'(HP2 + TOL);
  localparam logic [CW:0] LO3 = (CW+1)'(HP3 - TOL), HI3 = (CW+1)'(HP3 + TOL);
  localparam logic [4:0] DIG_OFF = 5'd20;
  localparam logic [4:0] DIG_B   = 5'd11;

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  logic          sync1_q, sync2_q, dly_q;
  logic          edge_w, timeout_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   hp;
  logic          hit;
  logic [1:0]    hit_id;
  state_t        state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic          cand_vld_q, cand_vld_d;
  logic [MW-1:0] match_q, match_d;
  logic          valid_q, valid_d;
  logic [1:0]    id_q, id_d;
  logic [9:0]    stled_q, stled_d;
  logic [4:0]    data_1_q, data_1_d, data_0_q, data_0_d;

  // Two-flop synchronizer plus a delay stage; any level change is an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign edge_w    = sync2_q ^ dly_q;
  assign timeout_w = !edge_w && (cnt_q == TO_CNT);
  assign hp        = (CW+1)'(cnt_q) + (CW+1)'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_w)                cnt_d = '0;
    else if (cnt_q != TO_CNT)  cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    hit    = 1'b1;
    hit_id = 2'd0;
    if      (hp >= LO0 && hp <= HI0) hit_id = 2'd0;
    else if (hp >= LO1 && hp <= HI1) hit_id = 2'd1;
    else if (hp >= LO2 && hp <= HI2) hit_id = 2'd2;
    else if (hp >= LO3 && hp <= HI3) hit_id = 2'd3;
    else                             hit    = 1'b0;
  end

  // An edge always takes precedence over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    match_d    = match_q;
    valid_d    = valid_q;
    id_d       = id_q;
    if (edge_w) begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_ACQ;
          cand_vld_d = 1'b0;
          match_d    = '0;
        end
        S_ACQ: begin
          if (!hit) begin
            cand_vld_d = 1'b0;
            match_d    = '0;
          end else begin
            if (cand_vld_q && hit_id == cand_q) begin
              match_d = match_q + MW'(1);
            end else begin
              cand_d     = hit_id;
              cand_vld_d = 1'b1;
              match_d    = MW'(1);
            end
            if (match_d == LOCK_M) begin
              state_d = S_LOCKED;
              valid_d = 1'b1;
              id_d    = cand_d;
            end
          end
        end
        S_LOCKED: begin
          if (!(hit && hit_id == id_q)) begin
            state_d = S_ACQ;
            valid_d = 1'b0;
            if (hit) begin
              cand_d     = hit_id;
              cand_vld_d = 1'b1;
              match_d    = MW'(1);
            end else begin
              cand_vld_d = 1'b0;
              match_d    = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_w) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end
  end

  always_comb begin
    stled_d  = valid_d ? (10'd1 << id_d) : 10'd0;
    data_1_d = valid_d ? DIG_B : DIG_OFF;
    data_0_d = valid_d ? {3'b000, id_d} : DIG_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      cand_q     <= 2'd0;
      cand_vld_q <= 1'b0;
      match_q    <= '0;
      valid_q    <= 1'b0;
      id_q       <= 2'd0;
      stled_q    <= 10'd0;
      data_1_q   <= DIG_OFF;
      data_0_q   <= DIG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      match_q    <= match_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      stled_q    <= stled_d;
      data_1_q   <= data_1_d;
      data_0_q   <= data_0_d;
    end
  end

  assign tone_valid = valid_q;
  assign tone_id    = id_q;
  assign stled      = stled_q;
  assign data_1     = data_1_q;
  assign data_0     = data_0_q;

endmodule
